// File: rtl/fft_pingpong_buf.sv
// Ping-pong frame buffer between the FFT butterfly output and the unload logic.
// One bank fills while the other drains through a credit-controlled skid FIFO.
module fft_pingpong_buf #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter bit BIT_REV_RD = 1'b1,
    parameter bit OUTPUT_REG = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic [1:0]            full_banks
);

    localparam int DEPTH = OUTPUT_REG ? 3 : 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

    bank_state_t           bank_state [2];
    logic                  wb, rb;
    logic [ADDR_WIDTH-1:0] wcnt, rcnt, rd_addr;
    logic [DATA_WIDTH-1:0] mem [2**(ADDR_WIDTH+1)];
    logic [DATA_WIDTH-1:0] ram_q, push_data;
    logic                  ram_vld, ram_last, stage2_vld;
    logic                  push_vld, push_last;
    logic [DATA_WIDTH-1:0] fifo_data [4];
    logic                  fifo_last [4];
    logic [1:0]            fifo_wptr, fifo_rptr, fifo_count;
    logic [2:0]            occupancy;
    logic                  wr_accept, rd_issue, rd_pop;

    function automatic logic [ADDR_WIDTH-1:0] bit_reverse(input logic [ADDR_WIDTH-1:0] x);
        logic [ADDR_WIDTH-1:0] r;
        for (int i = 0; i < ADDR_WIDTH; i++) r[i] = x[ADDR_WIDTH-1-i];
        return r;
    endfunction

    function automatic logic is_held(input bank_state_t s);
        return (s == FULL) || (s == DRAINING);
    endfunction

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign wr_ready  = !rst && (bank_state[wb] == EMPTY || bank_state[wb] == FILLING);
    assign wr_accept = wr_valid && wr_ready;
    assign rd_valid  = (fifo_count != 2'd0);
    assign rd_pop    = rd_valid && rd_ready;
    assign rd_data   = fifo_data[fifo_rptr];
    assign rd_last   = rd_valid && fifo_last[fifo_rptr];
    assign rd_addr   = BIT_REV_RD ? bit_reverse(rcnt) : rcnt;

    // A pop this cycle frees a slot in time for a read issued now, which keeps full rate.
    assign occupancy = {1'b0, fifo_count} + {2'b0, ram_vld} + {2'b0, stage2_vld};
    assign rd_issue  = is_held(bank_state[rb]) && (occupancy < (3'(DEPTH) + {2'b0, rd_pop}));

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_state[0] <= EMPTY;
            bank_state[1] <= EMPTY;
            wb            <= 1'b0;
            rb            <= 1'b0;
            wcnt          <= '0;
            rcnt          <= '0;
            full_banks    <= 2'd0;
        end else begin
            // Write and read never target the same bank in one cycle: their legal states are disjoint.
            if (wr_accept) begin
                bank_state[wb] <= (wcnt == LAST_IDX) ? FULL : FILLING;
                wcnt           <= wcnt + ADDR_WIDTH'(1);
                if (wcnt == LAST_IDX) wb <= ~wb;
            end
            if (rd_issue) begin
                bank_state[rb] <= (rcnt == LAST_IDX) ? EMPTY : DRAINING;
                rcnt           <= rcnt + ADDR_WIDTH'(1);
                if (rcnt == LAST_IDX) rb <= ~rb;
            end
            full_banks <= {1'b0, is_held(bank_state[0])} + {1'b0, is_held(bank_state[1])};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem[{wb, wcnt}] <= wr_data;
        if (rd_issue)  ram_q <= mem[{rb, rd_addr}];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_vld  <= 1'b0;
            ram_last <= 1'b0;
        end else begin
            ram_vld  <= rd_issue;
            ram_last <= (rcnt == LAST_IDX);
        end
    end

    if (OUTPUT_REG) begin : g_oreg
        logic [DATA_WIDTH-1:0] oreg_q;
        logic                  oreg_vld, oreg_last;

        always_ff @(posedge clk) begin
            if (rst) begin
                oreg_q    <= '0;
                oreg_vld  <= 1'b0;
                oreg_last <= 1'b0;
            end else begin
                oreg_q    <= ram_q;
                oreg_vld  <= ram_vld;
                oreg_last <= ram_last;
            end
        end

        assign stage2_vld = oreg_vld;
        assign push_vld   = oreg_vld;
        assign push_data  = oreg_q;
        assign push_last  = oreg_last;
    end else begin : g_no_oreg
        assign stage2_vld = 1'b0;
        assign push_vld   = ram_vld;
        assign push_data  = ram_q;
        assign push_last  = ram_last;
    end

    // Skid FIFO never overflows because every push was reserved by a credit at issue time.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wptr  <= 2'd0;
            fifo_rptr  <= 2'd0;
            fifo_count <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (push_vld) begin
                fifo_data[fifo_wptr] <= push_data;
                fifo_last[fifo_wptr] <= push_last;
                fifo_wptr            <= next_ptr(fifo_wptr);
            end
            if (rd_pop) fifo_rptr <= next_ptr(fifo_rptr);
            if (push_vld && !rd_pop)      fifo_count <= fifo_count + 2'd1;
            else if (!push_vld && rd_pop) fifo_count <= fifo_count - 2'd1;
        end
    end

endmodule

// File: tb/tb_fft_pingpong_buf.sv
// Self-checking bench: two buffer configurations scored against a frame-level reorder model.
module tb_fft_pingpong_buf;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int N  = 8;

    logic          clk, rst;
    logic [DW-1:0] wr_data_v [2];
    logic          wr_valid_v [2];
    logic          wr_ready_v [2];
    logic [DW-1:0] rd_data_v [2];
    logic          rd_valid_v [2];
    logic          rd_ready_v [2];
    logic          rd_last_v [2];
    logic [1:0]    full_banks_v [2];

    int checks = 0;
    int errors = 0;

    logic [DW:0]   exp_mem [2][256];
    int            exp_wr [2];
    int            exp_rd [2];
    logic [DW-1:0] part [2][N];
    int            wpos [2];
    int            pops [2];
    logic          hold [2];
    logic [DW-1:0] held_data [2];

    fft_pingpong_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BIT_REV_RD(1'b1), .OUTPUT_REG(1'b0)) dut_rev (
        .clk(clk), .rst(rst),
        .wr_data(wr_data_v[0]), .wr_valid(wr_valid_v[0]), .wr_ready(wr_ready_v[0]),
        .rd_data(rd_data_v[0]), .rd_valid(rd_valid_v[0]), .rd_ready(rd_ready_v[0]),
        .rd_last(rd_last_v[0]), .full_banks(full_banks_v[0])
    );

    fft_pingpong_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BIT_REV_RD(1'b0), .OUTPUT_REG(1'b1)) dut_nat (
        .clk(clk), .rst(rst),
        .wr_data(wr_data_v[1]), .wr_valid(wr_valid_v[1]), .wr_ready(wr_ready_v[1]),
        .rd_data(rd_data_v[1]), .rd_valid(rd_valid_v[1]), .rd_ready(rd_ready_v[1]),
        .rd_last(rd_last_v[1]), .full_banks(full_banks_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rev3(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a completed frame is queued in read order (bit-reversed for instance 0).
    task automatic scoreboardStep();
        logic [DW:0] e;
        int idx;
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                wpos[s]   = 0;
                exp_rd[s] = exp_wr[s];
                hold[s]   = 1'b0;
            end else begin
                if (hold[s]) begin
                    checkOutput("hold_valid", 32'(rd_valid_v[s]), 32'd1);
                    checkOutput("hold_data", 32'(rd_data_v[s]), 32'(held_data[s]));
                end
                if (wr_valid_v[s] && wr_ready_v[s]) begin
                    part[s][wpos[s]] = wr_data_v[s];
                    wpos[s]++;
                    if (wpos[s] == N) begin
                        for (int k = 0; k < N; k++) begin
                            idx = (s == 0) ? rev3(k) : k;
                            exp_mem[s][exp_wr[s] % 256] = {(k == N - 1), part[s][idx]};
                            exp_wr[s]++;
                        end
                        wpos[s] = 0;
                    end
                end
                if (rd_valid_v[s] && rd_ready_v[s]) begin
                    if (exp_rd[s] == exp_wr[s]) begin
                        checkOutput("spurious_out", 32'(rd_valid_v[s]), 32'd0);
                    end else begin
                        e = exp_mem[s][exp_rd[s] % 256];
                        checkOutput("rd_data", 32'(rd_data_v[s]), 32'(e[DW-1:0]));
                        checkOutput("rd_last", 32'(rd_last_v[s]), 32'(e[DW]));
                        exp_rd[s]++;
                    end
                    pops[s]++;
                end
                hold[s]      = rd_valid_v[s] && !rd_ready_v[s];
                held_data[s] = rd_data_v[s];
            end
        end
    endtask

    task automatic applyStimulus(input int s, input logic v, input logic [DW-1:0] d, input logic rdy,
                                 output logic acc, output logic pop);
        for (int j = 0; j < 2; j++) begin
            wr_valid_v[j] = (j == s) ? v : 1'b0;
            wr_data_v[j]  = (j == s) ? d : '0;
            rd_ready_v[j] = (j == s) ? rdy : 1'b1;
        end
        @(negedge clk);
        acc = wr_valid_v[s] && wr_ready_v[s];
        pop = rd_valid_v[s] && rd_ready_v[s];
        scoreboardStep();
        @(posedge clk);
        #1;
    endtask

    task automatic sendSamples(input int s, input int total, input bit rnd, input int ready_pct, input int base);
        int sent = 0;
        int spent = 0;
        logic [DW-1:0] d;
        logic v, r, a, p;
        d = rnd ? DW'($urandom) : DW'(base);
        while (sent < total && spent < 4000) begin
            v = rnd ? ($urandom_range(99) < 70) : 1'b1;
            r = ($urandom_range(99) < ready_pct);
            applyStimulus(s, v, d, r, a, p);
            if (a) begin
                sent++;
                d = rnd ? DW'($urandom) : DW'(base + sent);
            end
            spent++;
        end
        checkOutput("send_done", 32'(sent), 32'(total));
    endtask

    task automatic drainOut(input int s);
        int spent = 0;
        logic a, p;
        while ((exp_rd[s] != exp_wr[s] || rd_valid_v[s]) && spent < 200) begin
            applyStimulus(s, 1'b0, '0, 1'b1, a, p);
            spent++;
        end
        repeat (3) applyStimulus(s, 1'b0, '0, 1'b1, a, p);
        checkOutput("drain_pending", 32'(exp_wr[s] - exp_rd[s]), 32'd0);
        checkOutput("drain_valid", 32'(rd_valid_v[s]), 32'd0);
        checkOutput("drain_full_banks", 32'(full_banks_v[s]), 32'd0);
    endtask

    // Last write at edge T; rd_valid expected from T+2 (no output register) or T+3.
    task automatic latencyCheck(input int s, input int lat);
        logic a, p;
        for (int i = 0; i < N; i++) begin
            applyStimulus(s, 1'b1, DW'(i), 1'b1, a, p);
            checkOutput("lat_wr_ready", 32'(a), 32'd1);
        end
        checkOutput("lat_valid_T0", 32'(rd_valid_v[s]), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(s, 1'b0, '0, 1'b1, a, p);
            checkOutput("lat_valid", 32'(rd_valid_v[s]), 32'(k >= lat));
            if (k == 2) checkOutput("lat_full_banks", 32'(full_banks_v[s]), 32'd1);
        end
    endtask

    initial begin
        logic a, p;
        int acc_cnt, npop, first_c, last_c, p0;

        for (int s = 0; s < 2; s++) begin
            wr_valid_v[s] = 1'b0;
            wr_data_v[s]  = '0;
            rd_ready_v[s] = 1'b1;
            exp_wr[s] = 0;
            exp_rd[s] = 0;
            wpos[s]   = 0;
            pops[s]   = 0;
            hold[s]   = 1'b0;
            held_data[s] = '0;
        end
        rst = 1'b1;
        $display("[TB] start");

        applyStimulus(0, 1'b0, '0, 1'b1, a, p);
        for (int s = 0; s < 2; s++) begin
            checkOutput("rst_wr_ready", 32'(wr_ready_v[s]), 32'd0);
            checkOutput("rst_rd_valid", 32'(rd_valid_v[s]), 32'd0);
            checkOutput("rst_rd_data", 32'(rd_data_v[s]), 32'd0);
            checkOutput("rst_rd_last", 32'(rd_last_v[s]), 32'd0);
            checkOutput("rst_full_banks", 32'(full_banks_v[s]), 32'd0);
        end
        applyStimulus(0, 1'b0, '0, 1'b1, a, p);
        rst = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) checkOutput("wr_ready_after_rst", 32'(wr_ready_v[s]), 32'd1);

        latencyCheck(0, 2);
        drainOut(0);
        latencyCheck(1, 3);
        drainOut(1);

        acc_cnt = 0; npop = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 40; c++) begin
            applyStimulus(1, (acc_cnt < 2 * N), DW'(acc_cnt), 1'b1, a, p);
            if (acc_cnt < 2 * N) checkOutput("b2b_wr_ready", 32'(a), 32'd1);
            if (a) acc_cnt++;
            if (p) begin
                npop++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        checkOutput("b2b_count", 32'(npop), 32'd16);
        checkOutput("b2b_span", 32'(last_c - first_c), 32'd15);
        drainOut(1);

        p0 = pops[0];
        acc_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            applyStimulus(0, (acc_cnt < 3 * N), DW'(acc_cnt), 1'b0, a, p);
            if (a) acc_cnt++;
        end
        checkOutput("bp_accepted", 32'(acc_cnt), 32'd16);
        checkOutput("bp_wr_ready", 32'(wr_ready_v[0]), 32'd0);
        checkOutput("bp_full_banks", 32'(full_banks_v[0]), 32'd2);
        checkOutput("bp_rd_valid", 32'(rd_valid_v[0]), 32'd1);
        sendSamples(0, N, 1'b0, 100, 16);
        drainOut(0);
        checkOutput("bp_total_pops", 32'(pops[0] - p0), 32'd24);

        for (int s = 0; s < 2; s++) begin
            p0 = pops[s];
            sendSamples(s, 20 * N, 1'b1, 30, 0);
            drainOut(s);
            checkOutput("rand_pops", 32'(pops[s] - p0), 32'(20 * N));
        end

        acc_cnt = 0;
        for (int i = 0; i < N + 5; i++) begin
            applyStimulus(0, 1'b1, DW'(100 + i), 1'b0, a, p);
            if (a) acc_cnt++;
        end
        checkOutput("mid_accepted", 32'(acc_cnt), 32'd13);
        repeat (3) applyStimulus(0, 1'b0, '0, 1'b1, a, p);
        rst = 1'b1;
        applyStimulus(0, 1'b0, '0, 1'b1, a, p);
        checkOutput("mid_rst_rd_valid", 32'(rd_valid_v[0]), 32'd0);
        checkOutput("mid_rst_rd_data", 32'(rd_data_v[0]), 32'd0);
        checkOutput("mid_rst_rd_last", 32'(rd_last_v[0]), 32'd0);
        checkOutput("mid_rst_wr_ready", 32'(wr_ready_v[0]), 32'd0);
        checkOutput("mid_rst_full_banks", 32'(full_banks_v[0]), 32'd0);
        applyStimulus(0, 1'b0, '0, 1'b1, a, p);
        rst = 1'b0;
        #1;
        checkOutput("mid_wr_ready_after", 32'(wr_ready_v[0]), 32'd1);
        p0 = pops[0];
        sendSamples(0, N, 1'b0, 100, 200);
        drainOut(0);
        checkOutput("mid_fresh_pops", 32'(pops[0] - p0), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
